// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: branch-type codes and FSM encodings.
package pc_sequencer_pkg;
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_JMP  = 3'd1;
  localparam logic [2:0] BR_BZ   = 3'd2;
  localparam logic [2:0] BR_BNZ  = 3'd3;
  localparam logic [2:0] BR_CALL = 3'd4;
  localparam logic [2:0] BR_RET  = 3'd5;
  localparam logic [2:0] BR_HALT = 3'd6;

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_HALT   = 2'd3;
endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address LIFO: combinational top, push ignored when full, pop ignored when empty.
module pc_sequencer_ras #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_top_idx;

  assign w_top_idx = r_cnt[PW-1:0] - PW'(1);
  assign o_top     = r_mem[w_top_idx];
  assign o_full    = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_push && !o_full) begin
      r_mem[r_cnt[PW-1:0]] <= i_data;
      r_cnt                <= r_cnt + (PW+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter control unit: fetch/decode/halt sequencing and next-PC selection with call/return stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int          AW        = 8,
  parameter int          RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] next_pc,
  output logic          imem_req,
  input  logic          imem_ack,
  output logic          ir_load,
  input  logic          dec_valid,
  input  logic [2:0]    br_type,
  input  logic [AW-1:0] br_target,
  input  logic          flag_z,
  input  logic          stall,
  output logic          halted,
  output logic          stack_err
);
  logic [1:0]    r_state;
  logic          r_err;
  logic [1:0]    w_state_nxt;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_nxt;
  logic [AW-1:0] w_ras_top;
  logic          w_ras_full, w_ras_empty;
  logic          w_fire, w_push, w_pop, w_err_set;
  logic          w_req, w_irl, w_hlt;

  assign w_pc_inc = pc + AW'(1);
  assign w_fire   = (r_state == ST_DECODE) && !stall && dec_valid;
  assign w_push   = rst_n && w_fire && (br_type == BR_CALL);
  assign w_pop    = rst_n && w_fire && (br_type == BR_RET);
  assign w_err_set = (w_push && w_ras_full) || (w_pop && w_ras_empty);

  pc_sequencer_ras #(.AW(AW), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_full  (w_ras_full),
    .o_empty (w_ras_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_nxt       = pc;
    w_req       = 1'b0;
    w_irl       = 1'b0;
    w_hlt       = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_nxt       = RESET_VEC;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_irl       = 1'b1;
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_fire) begin
          w_state_nxt = ST_FETCH;
          case (br_type)
            BR_JMP:  w_nxt = br_target;
            BR_BZ:   w_nxt = flag_z  ? br_target : w_pc_inc;
            BR_BNZ:  w_nxt = !flag_z ? br_target : w_pc_inc;
            BR_CALL: w_nxt = br_target;
            BR_RET:  w_nxt = w_ras_empty ? w_pc_inc : w_ras_top;
            BR_HALT: begin
              w_nxt       = pc;
              w_state_nxt = ST_HALT;
            end
            default: w_nxt = w_pc_inc;
          endcase
        end
      end
      default: w_hlt = 1'b1;
    endcase
  end

  // Reset overrides every output in the same cycle, so an ack arriving then is dropped.
  assign next_pc   = rst_n ? w_nxt : RESET_VEC;
  assign imem_req  = rst_n && w_req;
  assign ir_load   = rst_n && w_irl;
  assign halted    = rst_n && w_hlt;
  assign stack_err = rst_n && r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end
endmodule
